// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the unified-memory arbiter: FSM state codes, port indices
// and the default memory latency.
package mem_arbiter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  localparam int MEM_LAT_DEFAULT = 1;
  // Wide enough for the legal latency range 1..7.
  localparam int CNT_W = 3;

endpackage

// File: rtl/arb_rr2.sv
// Combinational two-way pick between the CPU and DMA ports.
// Define ARB_FIXED_PRIO_EN to make the CPU port win every tie (DMA may starve).
module arb_rr2
  import mem_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_owner,
  output logic winner
);

`ifdef ARB_FIXED_PRIO_EN
  logic unused_last_owner;
  assign unused_last_owner = last_owner;
`endif

  always_comb begin
    winner = PORT_CPU;
    if (req0 && req1) begin
`ifdef ARB_FIXED_PRIO_EN
      winner = PORT_CPU;
`else
      winner = (last_owner == PORT_CPU) ? PORT_DMA : PORT_CPU;
`endif
    end else if (req1) begin
      winner = PORT_DMA;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter serialising CPU and DMA accesses onto one fixed-latency memory.
// Optional build macro ARB_FIXED_PRIO_EN (handled in arb_rr2) selects fixed CPU priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = MEM_LAT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT);

  logic [1:0]       state_reg, state_next;
  logic             owner_reg, owner_next;
  logic             we_reg, we_next;
  logic             last_owner_reg, last_owner_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [ADDR_W-1:0] addr_next;
  logic [DATA_W-1:0] wdata_next, rdata_next;
  logic gnt0_next, gnt1_next, done0_next, done1_next;
  logic mem_rd_next, mem_wr_next, busy_next;
  logic pick;

  arb_rr2 u_rr (
    .req0       (req0),
    .req1       (req1),
    .last_owner (last_owner_reg),
    .winner     (pick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (req0 || req1) state_next = ST_ISSUE;
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT:  if (cnt_reg == CNT_W'(1)) state_next = ST_DONE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Computes the next value of every registered output and of the latched transaction.
  always_comb begin
    owner_next      = owner_reg;
    we_next         = we_reg;
    last_owner_next = last_owner_reg;
    cnt_next        = cnt_reg;
    addr_next       = mem_addr;
    wdata_next      = mem_wdata;
    rdata_next      = rdata;
    case (state_reg)
      ST_IDLE: begin
        if (req0 || req1) begin
          owner_next = pick;
          we_next    = (pick == PORT_DMA) ? we1 : we0;
          addr_next  = (pick == PORT_DMA) ? addr1 : addr0;
          wdata_next = (pick == PORT_DMA) ? wdata1 : wdata0;
          cnt_next   = LAT_LOAD;
        end
      end
      ST_WAIT: begin
        cnt_next = cnt_reg - CNT_W'(1);
        if (cnt_reg == CNT_W'(1) && !we_reg) rdata_next = mem_rdata;
      end
      ST_DONE: last_owner_next = owner_reg;
      default: ;
    endcase
    gnt0_next   = (state_next == ST_ISSUE) && (owner_next == PORT_CPU);
    gnt1_next   = (state_next == ST_ISSUE) && (owner_next == PORT_DMA);
    done0_next  = (state_next == ST_DONE) && (owner_next == PORT_CPU);
    done1_next  = (state_next == ST_DONE) && (owner_next == PORT_DMA);
    mem_rd_next = (state_next == ST_ISSUE) && !we_next;
    mem_wr_next = (state_next == ST_ISSUE) && we_next;
    busy_next   = (state_next != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_reg      <= PORT_CPU;
      we_reg         <= 1'b0;
      last_owner_reg <= PORT_DMA;
      cnt_reg        <= '0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      rdata          <= '0;
      gnt0           <= 1'b0;
      gnt1           <= 1'b0;
      done0          <= 1'b0;
      done1          <= 1'b0;
      mem_rd         <= 1'b0;
      mem_wr         <= 1'b0;
      busy           <= 1'b0;
    end else begin
      owner_reg      <= owner_next;
      we_reg         <= we_next;
      last_owner_reg <= last_owner_next;
      cnt_reg        <= cnt_next;
      mem_addr       <= addr_next;
      mem_wdata      <= wdata_next;
      rdata          <= rdata_next;
      gnt0           <= gnt0_next;
      gnt1           <= gnt1_next;
      done0          <= done0_next;
      done1          <= done1_next;
      mem_rd         <= mem_rd_next;
      mem_wr         <= mem_wr_next;
      busy           <= busy_next;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: two instances (MEM_LAT 1 and 3), directed
// scenarios plus random traffic against a transaction-level timing model.
`timescale 1ns/1ps
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Arbitration rule: lone requester wins; a tie goes to the port that did not
  // complete the previous access (or always to port 0 with fixed priority).
  function automatic bit pick(bit r0, bit r1, bit last);
    if (r0 && r1) begin
`ifdef ARB_FIXED_PRIO_EN
      return 1'b0;
`else
      return !last;
`endif
    end
    return r0 ? 1'b0 : 1'b1;
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_lat
    localparam int LAT = (gi == 0) ? 1 : 3;

    logic rst = 1'b1;
    logic req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0, mem_rdata = '0;
    logic gnt0, gnt1, done0, done1, mem_rd, mem_wr, busy;
    logic [31:0] rdata, mem_addr, mem_wdata;

    bit chk_on = 1'b0;
    bit fin = 1'b0;
    int cyc = 0;
    int m_k = 0;
    int rd_seen = -100;
    logic [3:0] rd_idx = '0;
    bit m_act = 1'b0, m_we = 1'b0, m_owner = 1'b0, m_last = 1'b1;
    logic [31:0] m_addr = '0, m_wdata = '0, m_rd_val = '0, m_rdata_base = '0;
    logic [31:0] m_mem [16];
    logic [31:0] resp_mem [16];

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
      .clk(clk), .reset(rst),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
      .rdata(rdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .busy(busy)
    );

    function automatic string tg(input string s);
      return $sformatf("L%0d %s", LAT, s);
    endfunction

    // Memory: read data is valid only in the cycle LAT after the strobe, garbage otherwise.
    always @(negedge clk) begin
      if (mem_rd) begin rd_seen = cyc; rd_idx = mem_addr[5:2]; end
      if (mem_wr) resp_mem[mem_addr[5:2]] = mem_wdata;
    end
    always @(posedge clk) begin
      #1;
      mem_rdata = (cyc == rd_seen + LAT) ? resp_mem[rd_idx] : $urandom();
    end

    // Transaction model: an accepted request at edge k owns the memory until edge k+3+LAT.
    always @(posedge clk or negedge rst) begin
      if (!rst) begin
        m_act = 1'b0; m_last = 1'b1; m_addr = '0; m_wdata = '0; m_rdata_base = '0;
      end else begin
        cyc++;
        if ((!m_act || cyc >= m_k + 3 + LAT) && (req0 || req1)) begin
          if (m_act) begin
            m_last = m_owner;
            if (!m_we) m_rdata_base = m_rd_val;
          end
          m_owner = pick(req0, req1, m_last);
          m_we    = m_owner ? we1 : we0;
          m_addr  = m_owner ? addr1 : addr0;
          m_wdata = m_owner ? wdata1 : wdata0;
          if (m_we) m_mem[m_addr[5:2]] = m_wdata;
          else      m_rd_val = m_mem[m_addr[5:2]];
          m_k = cyc;
          m_act = 1'b1;
        end
      end
    end

    always @(negedge clk) begin : chk
      bit g, d, b;
      if (chk_on) begin
        g = m_act && (cyc == m_k);
        d = m_act && (cyc == m_k + 1 + LAT);
        b = m_act && (cyc >= m_k) && (cyc <= m_k + 1 + LAT);
        check(tg("gnt0"), 32'(gnt0), 32'(g && !m_owner));
        check(tg("gnt1"), 32'(gnt1), 32'(g && m_owner));
        check(tg("done0"), 32'(done0), 32'(d && !m_owner));
        check(tg("done1"), 32'(done1), 32'(d && m_owner));
        check(tg("mem_rd"), 32'(mem_rd), 32'(g && !m_we));
        check(tg("mem_wr"), 32'(mem_wr), 32'(g && m_we));
        check(tg("busy"), 32'(busy), 32'(b));
        check(tg("mem_addr"), mem_addr, m_addr);
        check(tg("mem_wdata"), mem_wdata, m_wdata);
        check(tg("rdata"), rdata,
              (m_act && !m_we && cyc >= m_k + 1 + LAT) ? m_rd_val : m_rdata_base);
      end
    end

    // which: 0 gnt0, 1 gnt1, 2 done0, 3 done1, 4 any gnt
    task automatic wait_ev(input int which, input string tag);
      for (int t = 0; t < 50; t++) begin
        @(negedge clk);
        if ((which == 0 && gnt0) || (which == 1 && gnt1) || (which == 2 && done0) ||
            (which == 3 && done1) || (which == 4 && (gnt0 || gnt1))) return;
      end
      check(tg({tag, " timeout"}), 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
      for (int t = 0; t < 50; t++) begin
        @(negedge clk);
        if (!busy) return;
      end
      check(tg("idle timeout"), 32'd0, 32'd1);
    endtask

    // Called at a falling edge; asserts reset mid-cycle and checks the asynchronous clear.
    task automatic do_reset(input bit r0, input bit r1);
      #2;
      rst = 1'b0;
      req0 = r0; req1 = r1; we0 = 1'b0; we1 = 1'b0;
      #1;
      check(tg("rst strobes"), 32'({gnt0, gnt1, done0, done1, mem_rd, mem_wr, busy}), 32'd0);
      check(tg("rst mem_addr"), mem_addr, 32'd0);
      check(tg("rst mem_wdata"), mem_wdata, 32'd0);
      check(tg("rst rdata"), rdata, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
    endtask

    initial begin : prog
      logic [31:0] v;
      int t0;
      for (int i = 0; i < 16; i++) begin v = $urandom(); resp_mem[i] = v; m_mem[i] = v; end
      resp_mem[4] = 32'hDEAD_BEEF;
      m_mem[4]    = 32'hDEAD_BEEF;
      @(negedge clk);
      do_reset(1'b0, 1'b0);
      chk_on = 1'b1;
      repeat (2) @(negedge clk);

      // Single read on port 0.
      req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10; wdata0 = $urandom();
      wait_ev(0, "rd gnt0");
      check(tg("rd strobe"), 32'(mem_rd), 32'd1);
      check(tg("rd addr"), mem_addr, 32'h10);
      t0 = cyc;
      req0 = 1'b0;
      wait_ev(2, "rd done0");
      check(tg("rd data"), rdata, 32'hDEAD_BEEF);
      check(tg("rd latency"), 32'(cyc - t0), 32'(LAT + 1));
      @(negedge clk);
      check(tg("rd busy drop"), 32'(busy), 32'd0);
      repeat (2) @(negedge clk);

      // Single write on port 1.
      req1 = 1'b1; we1 = 1'b1; addr1 = 32'h40; wdata1 = 32'h1234_5678;
      wait_ev(1, "wr gnt1");
      check(tg("wr strobe"), 32'(mem_wr), 32'd1);
      check(tg("wr addr"), mem_addr, 32'h40);
      check(tg("wr data"), mem_wdata, 32'h1234_5678);
      t0 = cyc;
      req1 = 1'b0;
      @(negedge clk);
      check(tg("wr strobe width"), 32'(mem_wr), 32'd0);
      wait_ev(3, "wr done1");
      check(tg("wr latency"), 32'(cyc - t0), 32'(LAT + 1));
      check(tg("wr rdata kept"), rdata, 32'hDEAD_BEEF);
      wait_idle();

      // Continuous contention from reset.
      do_reset(1'b1, 1'b1);
      t0 = 0;
      for (int i = 0; i < 4; i++) begin
        wait_ev(4, "rr gnt");
`ifdef ARB_FIXED_PRIO_EN
        check(tg("rr order"), 32'(gnt1), 32'd0);
`else
        check(tg("rr order"), 32'(gnt1), 32'(i % 2));
`endif
        if (i > 0) check(tg("rr spacing"), 32'(cyc - t0), 32'(LAT + 3));
        t0 = cyc;
      end
      req0 = 1'b0; req1 = 1'b0;
      wait_idle();

      // Reset during the wait phase of a port-0 read.
      req0 = 1'b1; we0 = 1'b0; addr0 = 32'h20; wdata0 = $urandom();
      wait_ev(0, "abort gnt0");
      req0 = 1'b0;
      @(negedge clk);
      check(tg("abort busy"), 32'(busy), 32'd1);
      do_reset(1'b1, 1'b1);
      wait_ev(4, "post-reset gnt");
      check(tg("post-reset first port"), 32'(gnt1), 32'd0);
      req0 = 1'b0;
      wait_ev(1, "post-reset gnt1");
      req1 = 1'b0;
      wait_idle();

      // DMA request arriving while the CPU access is in flight.
      req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10; wdata0 = $urandom();
      wait_ev(0, "late gnt0");
      req0 = 1'b0;
      @(negedge clk);
      req1 = 1'b1; we1 = 1'b1; addr1 = 32'h8; wdata1 = $urandom();
      wait_ev(2, "late done0");
      t0 = cyc;
      wait_ev(1, "late gnt1");
      check(tg("late gnt1 spacing"), 32'(cyc - t0), 32'd2);
      req1 = 1'b0;
      wait_idle();

      // Random traffic; requests are held until granted.
      for (int n = 0; n < 400; n++) begin
        @(negedge clk);
        if (req0 && gnt0) req0 = 1'b0;
        else if (!req0 && $urandom_range(0, 3) == 0) begin
          req0 = 1'b1; we0 = 1'($urandom()); addr0 = $urandom() & 32'hFFFF_FFFC; wdata0 = $urandom();
        end
        if (req1 && gnt1) req1 = 1'b0;
        else if (!req1 && $urandom_range(0, 3) == 0) begin
          req1 = 1'b1; we1 = 1'($urandom()); addr1 = $urandom() & 32'hFFFF_FFFC; wdata1 = $urandom();
        end
      end
      req0 = 1'b0; req1 = 1'b0;
      repeat (LAT + 4) @(negedge clk);
      wait_idle();
      fin = 1'b1;
    end
  end

  initial begin
    fork
      wait (g_lat[0].fin && g_lat[1].fin);
      #1000000;
    join_any
    if (!(g_lat[0].fin && g_lat[1].fin)) check("sim timeout", 32'd0, 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
